// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, timeout default, request record
// and the address map used by the decoder.
package bus_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  localparam int unsigned TimeoutDefault = 255;

  localparam logic [31:0] RamBase    = 32'h0000_0000;
  localparam logic [31:0] PeriphBase = 32'hE000_0000;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master request/response ports plus the shared downstream bus.
// master: arbiter view (drives bus_*); slave: requesting masters and the slave side.
interface bus_arbiter_if;
  logic        m0_request;
  logic [31:0] m0_address;
  logic        m0_write;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m0_error;

  logic        m1_request;
  logic [31:0] m1_address;
  logic        m1_write;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_error;

  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport master (
    input  m0_request, m0_address, m0_write, m0_wdata, m0_wstrb,
    output m0_ack, m0_rdata, m0_error,
    input  m1_request, m1_address, m1_write, m1_wdata, m1_wstrb,
    output m1_ack, m1_rdata, m1_error,
    output bus_request, bus_address, bus_write, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata, bus_error
  );

  modport slave (
    output m0_request, m0_address, m0_write, m0_wdata, m0_wstrb,
    input  m0_ack, m0_rdata, m0_error,
    output m1_request, m1_address, m1_write, m1_wdata, m1_wstrb,
    input  m1_ack, m1_rdata, m1_error,
    input  bus_request, bus_address, bus_write, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata, bus_error
  );
endinterface

// File: rtl/bus_pending_slot.sv
// One master's pending request. The effective outputs bypass the register so a
// request arriving in an idle cycle can be granted without waiting a cycle.
module bus_pending_slot
  import bus_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic request,
  input  req_t req_in,
  input  logic active,
  input  logic clear,
  output logic eff_valid,
  output req_t eff_req
);

  logic valid_q;
  req_t req_q;
  logic load;

  // Ignore a new request while this master still has one pending or on the bus.
  assign load      = request && !valid_q && !active;
  assign eff_valid = valid_q || load;
  assign eff_req   = valid_q ? req_q : req_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      req_q   <= req_in;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving two masters one-at-a-time access to a shared bus,
// with a per-transaction response timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic          clock,
  input logic          reset,
  bus_arbiter_if.master arb
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic            grant_q;
  logic            last_q;
  logic [CntW-1:0] count_q;

  logic        bus_request_q, bus_write_q;
  logic [31:0] bus_address_q, bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic        m0_ack_q, m1_ack_q, m0_error_q, m1_error_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  req_t m0_in, m1_in, m0_eff, m1_eff, sel;
  logic m0_valid, m1_valid, any_valid, pick, idle;
  logic timeout_hit;

  assign m0_in = '{address: arb.m0_address, write: arb.m0_write,
                   wdata: arb.m0_wdata, wstrb: arb.m0_wstrb};
  assign m1_in = '{address: arb.m1_address, write: arb.m1_write,
                   wdata: arb.m1_wdata, wstrb: arb.m1_wstrb};

  assign idle      = (state_q == StIdle);
  assign any_valid = m0_valid || m1_valid;
  // On a tie the master not granted last wins; otherwise whichever is pending.
  assign pick      = (m0_valid && m1_valid) ? !last_q : m1_valid;
  assign sel       = pick ? m1_eff : m0_eff;
  assign timeout_hit = (count_q == CntW'(TIMEOUT - 1));

  bus_pending_slot u_slot0 (
    .clock    (clock),
    .reset    (reset),
    .request  (arb.m0_request),
    .req_in   (m0_in),
    .active   (!idle && !grant_q),
    .clear    (idle && any_valid && !pick),
    .eff_valid(m0_valid),
    .eff_req  (m0_eff)
  );

  bus_pending_slot u_slot1 (
    .clock    (clock),
    .reset    (reset),
    .request  (arb.m1_request),
    .req_in   (m1_in),
    .active   (!idle && grant_q),
    .clear    (idle && any_valid && pick),
    .eff_valid(m1_valid),
    .eff_req  (m1_eff)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      count_q       <= '0;
      bus_request_q <= 1'b0;
      bus_address_q <= '0;
      bus_write_q   <= 1'b0;
      bus_wdata_q   <= '0;
      bus_wstrb_q   <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_error_q    <= 1'b0;
      m1_error_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      bus_request_q <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_error_q    <= 1'b0;
      m1_error_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            grant_q       <= pick;
            last_q        <= pick;
            count_q       <= '0;
            bus_request_q <= 1'b1;
            bus_address_q <= sel.address;
            bus_write_q   <= sel.write;
            bus_wdata_q   <= sel.wdata;
            bus_wstrb_q   <= sel.wstrb;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          // Error (slave or timeout) wins over a simultaneous ack.
          if (arb.bus_error || (!arb.bus_ack && timeout_hit)) begin
            m0_error_q <= !grant_q;
            m1_error_q <= grant_q;
            state_q    <= StIdle;
          end else if (arb.bus_ack) begin
            m0_ack_q <= !grant_q;
            m1_ack_q <= grant_q;
            if (grant_q) m1_rdata_q <= arb.bus_rdata;
            else         m0_rdata_q <= arb.bus_rdata;
            state_q <= StIdle;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arb.bus_request = bus_request_q;
  assign arb.bus_address = bus_address_q;
  assign arb.bus_write   = bus_write_q;
  assign arb.bus_wdata   = bus_wdata_q;
  assign arb.bus_wstrb   = bus_wstrb_q;
  assign arb.m0_ack      = m0_ack_q;
  assign arb.m1_ack      = m1_ack_q;
  assign arb.m0_error    = m0_error_q;
  assign arb.m1_error    = m1_error_q;
  assign arb.m0_rdata    = m0_rdata_q;
  assign arb.m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: latency, round-robin, timeout, error priority
// and mid-transaction reset, with a per-cycle pulse/exclusivity monitor.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned Timeout = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(Timeout)) dut (
    .clock(clock),
    .reset(reset),
    .arb  (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [3:0] ws);
    if (m == 0) begin
      bif.m0_request = 1'b1; bif.m0_address = a; bif.m0_write = w;
      bif.m0_wdata = wd; bif.m0_wstrb = ws;
    end else begin
      bif.m1_request = 1'b1; bif.m1_address = a; bif.m1_write = w;
      bif.m1_wdata = wd; bif.m1_wstrb = ws;
    end
  endtask

  task automatic slave(input logic ack, input logic err, input logic [31:0] rd);
    bif.bus_ack = ack; bif.bus_error = err; bif.bus_rdata = rd;
  endtask

  // Advance one cycle; every driven input is a one-cycle pulse.
  task automatic step();
    @(negedge clock);
    bif.m0_request = 1'b0; bif.m1_request = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_error = 1'b0;
  endtask

  logic [4:0] prev_p = '0;
  always @(negedge clock) begin
    logic [4:0] cur;
    cur = {bif.bus_request, bif.m0_ack, bif.m1_ack, bif.m0_error, bif.m1_error};
    check("ack_err_onehot", 32'($countones(cur[3:0]) <= 1), 32'd1);
    check("pulse_repeat", 32'(|(cur & prev_p)), 32'd0);
    prev_p = cur;
  end

  initial begin
    int seen;
    bif.m0_request = 0; bif.m0_address = 0; bif.m0_write = 0; bif.m0_wdata = 0; bif.m0_wstrb = 0;
    bif.m1_request = 0; bif.m1_address = 0; bif.m1_write = 0; bif.m1_wdata = 0; bif.m1_wstrb = 0;
    bif.bus_ack = 0; bif.bus_rdata = 0; bif.bus_error = 0;
    @(negedge clock);
    @(negedge clock);
    check("rst_bus_request", 32'(bif.bus_request), 32'd0);
    check("rst_bus_address", bif.bus_address, 32'h0);
    check("rst_m0_ack", 32'(bif.m0_ack), 32'd0);
    check("rst_m1_rdata", bif.m1_rdata, 32'h0);
    reset = 1'b0;
    step();

    // Single read, slave acks three cycles after bus_request.
    req(0, RamBase + 32'h100, 1'b0, 32'h0, 4'h0);
    step();
    check("t1_req_latency", 32'(bif.bus_request), 32'd1);
    check("t1_addr", bif.bus_address, 32'h0000_0100);
    check("t1_write", 32'(bif.bus_write), 32'd0);
    req(0, 32'h0000_0999, 1'b1, 32'h1, 4'h1);  // m0 already active: ignored
    step();
    check("t1_req_pulse", 32'(bif.bus_request), 32'd0);
    step();
    step();
    check("t1_no_early_ack", 32'(bif.m0_ack), 32'd0);
    slave(1'b1, 1'b0, 32'hDEAD_BEEF);
    step();
    check("t1_ack", 32'(bif.m0_ack), 32'd1);
    check("t1_rdata", bif.m0_rdata, 32'hDEAD_BEEF);
    step();
    check("t1_ack_pulse", 32'(bif.m0_ack), 32'd0);
    check("t1_ignored_req", 32'(bif.bus_request), 32'd0);
    step();

    // Tie from reset: m0 first, m1 one cycle after m0_ack.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req(0, 32'h0000_0200, 1'b0, 32'h0, 4'h0);
    req(1, 32'h0000_0300, 1'b0, 32'h0, 4'h0);
    step();
    check("t2_first_req", 32'(bif.bus_request), 32'd1);
    check("t2_first_addr", bif.bus_address, 32'h0000_0200);
    slave(1'b1, 1'b0, 32'h1111_1111);
    step();
    check("t2_m0_ack", 32'(bif.m0_ack), 32'd1);
    check("t2_m0_rdata", bif.m0_rdata, 32'h1111_1111);
    check("t2_idle_gap", 32'(bif.bus_request), 32'd0);
    step();
    check("t2_second_req", 32'(bif.bus_request), 32'd1);
    check("t2_second_addr", bif.bus_address, 32'h0000_0300);
    slave(1'b1, 1'b0, 32'h2222_2222);
    step();
    check("t2_m1_ack", 32'(bif.m1_ack), 32'd1);
    check("t2_m1_rdata", bif.m1_rdata, 32'h2222_2222);
    // Both request again, m1 in its own ack cycle.
    req(0, 32'h0000_0400, 1'b0, 32'h0, 4'h0);
    req(1, 32'h0000_0500, 1'b0, 32'h0, 4'h0);
    step();
    check("t2_rr_m0_req", 32'(bif.bus_request), 32'd1);
    check("t2_rr_m0_addr", bif.bus_address, 32'h0000_0400);
    slave(1'b1, 1'b0, 32'h3333_3333);
    step();
    check("t2_rr_m0_ack", 32'(bif.m0_ack), 32'd1);
    check("t2_rr_m0_rdata", bif.m0_rdata, 32'h3333_3333);
    step();
    check("t2_rr_m1_req", 32'(bif.bus_request), 32'd1);
    check("t2_rr_m1_addr", bif.bus_address, 32'h0000_0500);
    slave(1'b1, 1'b0, 32'h4444_4444);
    step();
    check("t2_rr_m1_ack", 32'(bif.m1_ack), 32'd1);
    check("t2_rr_m1_rdata", bif.m1_rdata, 32'h4444_4444);
    step();

    // Write with no slave response: timeout error, stray ack ignored.
    req(1, PeriphBase + 32'h10, 1'b1, 32'h1234_5678, 4'hF);
    step();
    check("t3_req", 32'(bif.bus_request), 32'd1);
    check("t3_addr", bif.bus_address, 32'hE000_0010);
    check("t3_write", 32'(bif.bus_write), 32'd1);
    check("t3_wdata", bif.bus_wdata, 32'h1234_5678);
    check("t3_wstrb", 32'(bif.bus_wstrb), 32'hF);
    for (int i = 1; i < Timeout; i++) step();
    check("t3_no_early_err", 32'(bif.m1_error), 32'd0);
    step();
    check("t3_timeout_err", 32'(bif.m1_error), 32'd1);
    check("t3_no_ack", 32'(bif.m1_ack), 32'd0);
    slave(1'b1, 1'b0, 32'hFFFF_FFFF);
    step();
    check("t3_stray_ack", 32'(bif.m1_ack), 32'd0);
    step();
    check("t3_stray_ack2", 32'(bif.m1_ack), 32'd0);
    check("t3_no_req", 32'(bif.bus_request), 32'd0);

    // Decoder error together with ack: error only.
    req(0, 32'h5000_0000, 1'b0, 32'h0, 4'h0);
    step();
    check("t4_req", 32'(bif.bus_request), 32'd1);
    check("t4_addr", bif.bus_address, 32'h5000_0000);
    slave(1'b1, 1'b1, 32'hBAD0_BAD0);
    step();
    check("t4_error", 32'(bif.m0_error), 32'd1);
    check("t4_no_ack", 32'(bif.m0_ack), 32'd0);
    step();
    check("t4_error_pulse", 32'(bif.m0_error), 32'd0);

    // Reset while m1 is on the bus.
    req(1, 32'h0000_0600, 1'b1, 32'hAAAA_5555, 4'h3);
    step();
    check("t5_req", 32'(bif.bus_request), 32'd1);
    step();
    reset = 1'b1;
    #1;
    check("t5_rst_address", bif.bus_address, 32'h0);
    check("t5_rst_wdata", bif.bus_wdata, 32'h0);
    check("t5_rst_write", 32'(bif.bus_write), 32'd0);
    check("t5_rst_m0_rdata", bif.m0_rdata, 32'h0);
    check("t5_rst_m1_rdata", bif.m1_rdata, 32'h0);
    step();
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(Timeout) + 4; i++) begin
      step();
      seen += int'(bif.m1_ack) + int'(bif.m1_error) + int'(bif.bus_request);
    end
    check("t5_abandoned", 32'(seen), 32'd0);
    req(0, 32'h0000_0700, 1'b0, 32'h0, 4'h0);
    step();
    check("t5_new_req", 32'(bif.bus_request), 32'd1);
    check("t5_new_addr", bif.bus_address, 32'h0000_0700);
    slave(1'b1, 1'b0, 32'hCAFE_F00D);
    step();
    check("t5_new_ack", 32'(bif.m0_ack), 32'd1);
    check("t5_new_rdata", bif.m0_rdata, 32'hCAFE_F00D);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
